// File: rtl/alu_mul_result_stage.sv
// Execute-stage result block: ALU pass-through, MFHI/MFLO mux and a shift-add HI/LO multiplier.
// Optional signed MULT support is enabled by defining MUL_SIGNED_EN.
module alu_mul_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] aluOut,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // state is the FSM observation point for checkers.
    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   multiplier;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] multiplicand;
    logic [2*WIDTH-1:0] product_sum;
    logic [2*WIDTH-1:0] result;
    logic [CNT_W-1:0]   counter;
    logic [WIDTH-1:0]   load_a;
    logic [WIDTH-1:0]   load_b;
    logic               accept;
    logic               last_iter;

`ifdef MUL_SIGNED_EN
    localparam logic [5:0] MULT = 6'b011000;

    logic is_mult;
    logic sign;

    // Signed multiply runs the unsigned engine on magnitudes and fixes the sign at commit.
    assign is_mult = (Signal == MULT);
    assign accept  = in_valid && ((Signal == MULTU) || is_mult) && (state != MUL);
    assign load_a  = (is_mult && dataA[WIDTH-1]) ? -dataA : dataA;
    assign load_b  = (is_mult && dataB[WIDTH-1]) ? -dataB : dataB;
    assign result  = sign ? -product_sum : product_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign <= 1'b0;
        end else if (accept) begin
            sign <= is_mult && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
        end
    end
`else
    assign accept = in_valid && (Signal == MULTU) && (state != MUL);
    assign load_a = dataA;
    assign load_b = dataB;
    assign result = product_sum;
`endif

    assign product_sum = product + (multiplier[0] ? multiplicand : '0);
    assign last_iter   = (counter == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = MUL;
            end
            MUL: begin
                busy = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = accept ? MUL : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // HI/LO are written only on the final iteration, so an aborted run never leaks out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi           <= '0;
            lo           <= '0;
            product      <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
            counter      <= '0;
        end else if (accept) begin
            multiplicand <= {{WIDTH{1'b0}}, load_a};
            multiplier   <= load_b;
            product      <= '0;
            counter      <= '0;
        end else if (state == MUL) begin
            product      <= product_sum;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            counter      <= counter + CNT_W'(1);
            if (last_iter) begin
                {hi, lo} <= result;
            end
        end
    end

    always_comb begin
        dataOut = aluOut;
        if (Signal == MFHI) begin
            dataOut = hi;
        end else if (Signal == MFLO) begin
            dataOut = lo;
        end
    end

endmodule

// File: doc/alu_mul_result_stage.md
Name: alu_mul_result_stage

Overview:
- Execute-stage result block directly downstream of the 32-bit combinational ALU.
- Consumes the ALU result and the same operand/function bus.
- Contains a 32-cycle shift-add unsigned multiplier writing the HI/LO registers.
- Final result mux selects the ALU result or HI/LO for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand/result width; HI and LO are each WIDTH bits; the product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies Signal/dataA/dataB for the current cycle.
- dataA  input  WIDTH  operand A, same bus as the ALU input; multiplicand.
- dataB  input  WIDTH  operand B, same bus as the ALU input; multiplier.
- Signal  input  6  function code, same encoding as the ALU.
- aluOut  input  WIDTH  ALU result for the current cycle.
- dataOut  output  WIDTH  stage result.
- busy  output  1  multiplier iterating.
- done  output  1  one-cycle pulse when HI/LO have just been written.

Behaviour:
- Function codes:
  - MULTU = 6'b011001 (25)
  - MFHI = 6'b010000 (16)
  - MFLO = 6'b010010 (18)
  - All other codes pass through.
- Reset (async, immediate): state=IDLE, HI=0, LO=0, product/multiplicand/multiplier/counter=0, busy=0, done=0.
- dataOut is combinational:
  - Signal==MFHI -> HI.
  - Signal==MFLO -> LO.
  - Otherwise -> aluOut.
  - Independent of in_valid and busy.
- FSM states: IDLE, MUL, DONE.
- Accept: in_valid && Signal==MULTU && state in {IDLE, DONE}. On the accept edge:
  - multiplicand <= zero-extended dataA (2*WIDTH bits).
  - multiplier <= dataB.
  - product <= 0, counter <= 0.
  - state <= MUL.
- MUL, each cycle:
  - If multiplier[0], product += multiplicand (2*WIDTH-bit, no overflow possible).
  - multiplicand <<= 1; multiplier >>= 1; counter++.
  - Exactly WIDTH (32) MUL cycles.
  - On the edge ending the 32nd cycle: {HI,LO} <= final product (including that cycle's add); state <= DONE.
- DONE: lasts one cycle. Next state is IDLE, or MUL if a new MULTU is accepted in that cycle.
- Outputs: busy=1 exactly in MUL; done=1 exactly in DONE.
- Latency:
  - Accept at cycle T; busy high T+1..T+32.
  - done high and new HI/LO visible at T+33.
  - MFHI/MFLO issued at T+33 returns the new value.
- HI/LO change only on MUL->DONE (or reset). During busy, MFHI/MFLO return the previous committed values.
- MULTU while busy is ignored: no restart, no error flag, HI/LO unaffected.
- Non-MULTU codes never affect multiplier state.
- Reset mid-operation aborts immediately: HI/LO=0, busy/done=0. The discarded product is never committed.
- Operands are sampled only on accept; dataA/dataB may change freely during MUL.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined:
  - Adds MULT = 6'b011000 (24), signed two's-complement multiply.
  - On accept, magnitudes of dataA/dataB are loaded and sign = dataA[31]^dataB[31] is registered.
  - On commit, {HI,LO} = sign ? -product : product (2*WIDTH-bit negate).
  - Timing is identical to MULTU.
  - Most-negative operands: 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- Undefined: code 24 is a pass-through like any other non-special code, and no sign logic is synthesised.

Test Plan:
- Reset, then MULTU dataA=7 dataB=6 at T -> busy T+1..T+32; done=1 at T+33; MFLO=42, MFHI=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> MFHI=0xFFFFFFFE, MFLO=0x00000001 at T+33; 0*0x12345678 -> HI=LO=0.
- After HI=0, LO=42: MULTU 0x10000*0x10000; MFLO at T+10 returns 42; MULTU issued at T+5 ignored; at T+33 HI=1, LO=0.
- Back-to-back: second MULTU 3*3 issued at the done cycle -> accepted, busy next cycle, LO=9 after 33 more cycles.
- Reset asserted at T+10 of a 5*5 multiply -> busy/done immediately 0; after release MFLO=0 and MFHI=0; no done pulse.
- Pass-through: Signal=ADD(32), aluOut=0xDEADBEEF -> dataOut=0xDEADBEEF regardless of busy. With MUL_SIGNED_EN: MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
